dram_line_controller: RTL

// - Initiator side of the line-wide DRAM interface: turns single cache-line read/write requests into DRAM enable/address/data sequences.
// - Holds enable and address stable for the whole DRAM latency, then returns the result through a valid/ready response channel.
// - Sits between a cache refill/writeback unit (upstream) and the DRAM emulation memory (downstream).

---
 rtl/dram_ctrl_pkg.sv | 18 +
 rtl/dram_line_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared types and helpers for the line-wide DRAM initiator.
//   dram_ctrl_state_t : controller FSM encoding
//   line_size()       : line width in bits for a given byte-offset width
package dram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } dram_ctrl_state_t;

  // A line holds 2**bob bytes, i.e. 32 * 2**(bob-2) bits.
  function automatic int line_size(input int bob);
    return 32 * (2 ** (bob - 2));
  endfunction

endpackage

// File: rtl/dram_line_controller.sv
// dram_line_controller: turns single cache-line read/write requests into a
// DRAM enable/address/data sequence and returns the result on a valid/ready
// response channel.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   req_valid_i/req_ready_o          request handshake (accepted only in IDLE)
//   req_we_i, req_addr_i, req_wdata_i request type, byte address, write line
//   rsp_valid_o/rsp_ready_i          response handshake (held until ready)
//   rsp_we_o, rsp_err_o, rsp_rdata_o response type, timeout flag, read line
//   mem_add_o, mem_read_enable_o,
//   mem_write_enable_o, mem_data_o   DRAM command side (line-aligned address)
//   mem_read_valid_i, mem_write_valid_i,
//   mem_data_i                       DRAM completion pulses and read line
module dram_line_controller
  import dram_ctrl_pkg::*;
#(
  parameter int  BYTE_OFFSET_BITS = 5,
  parameter int  TIMEOUT_CYCLES   = 64,
  localparam int LINE_SIZE        = line_size(BYTE_OFFSET_BITS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [31:0]          req_addr_i,
  input  logic [LINE_SIZE-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_we_o,
  output logic                 rsp_err_o,
  output logic [LINE_SIZE-1:0] rsp_rdata_o,
  output logic [31:0]          mem_add_o,
  output logic                 mem_read_enable_o,
  output logic                 mem_write_enable_o,
  output logic [LINE_SIZE-1:0] mem_data_o,
  input  logic                 mem_read_valid_i,
  input  logic                 mem_write_valid_i,
  input  logic [LINE_SIZE-1:0] mem_data_i
);

  localparam int          TIMER_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << BYTE_OFFSET_BITS) - 32'd1);

  dram_ctrl_state_t       state_r;
  dram_ctrl_state_t       state_s;
  logic [31:0]            addr_r;
  logic                   we_r;
  logic [LINE_SIZE-1:0]   wdata_r;
  logic [LINE_SIZE-1:0]   rdata_r;
  logic                   err_r;
  logic [TIMER_W-1:0]     timer_r;
  // Registered expiry flag: adds one cycle so the timeout path matches the
  // registered-valid path of a normal completion.
  logic                   timeout_r;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a DRAM valid wins over a simultaneous timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i) begin
          state_s = req_we_i ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (mem_read_valid_i || timeout_r) begin
          state_s = RESP;
        end else begin
          state_s = READ;
        end
      end
      WRITE: begin
        if (mem_write_valid_i || timeout_r) begin
          state_s = RESP;
        end else begin
          state_s = WRITE;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Request capture, timeout counter and response data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r    <= 32'd0;
      we_r      <= 1'b0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      timer_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            addr_r    <= req_addr_i & LINE_MASK;
            we_r      <= req_we_i;
            wdata_r   <= req_wdata_i;
            rdata_r   <= '0;
            err_r     <= 1'b0;
            timer_r   <= '0;
            timeout_r <= 1'b0;
          end
        end
        READ: begin
          if (mem_read_valid_i) begin
            rdata_r <= mem_data_i;
            err_r   <= 1'b0;
          end else if (timeout_r) begin
            rdata_r <= '0;
            err_r   <= 1'b1;
          end else begin
            timer_r   <= timer_r + TIMER_W'(1);
            timeout_r <= (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1));
          end
        end
        WRITE: begin
          if (mem_write_valid_i) begin
            rdata_r <= '0;
            err_r   <= 1'b0;
          end else if (timeout_r) begin
            rdata_r <= '0;
            err_r   <= 1'b1;
          end else begin
            timer_r   <= timer_r + TIMER_W'(1);
            timeout_r <= (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1));
          end
        end
        default: begin
          // RESP: everything held so the response is stable under backpressure.
        end
      endcase
    end
  end

  // Handshakes and DRAM enables come straight from the state register, so no
  // request or DRAM-valid input can reach them combinationally.
  assign req_ready_o        = (state_r == IDLE);
  assign rsp_valid_o        = (state_r == RESP);
  assign mem_read_enable_o  = (state_r == READ);
  assign mem_write_enable_o = (state_r == WRITE);
  assign mem_add_o          = addr_r;
  assign mem_data_o         = wdata_r;
  assign rsp_we_o           = we_r;
  assign rsp_err_o          = err_r;
  assign rsp_rdata_o        = rdata_r;

endmodule
